imem_loader: RTL

- Write-side counterpart to the CPU's instruction fetch path. Receives a byte stream over a valid/ready handshake and assembles it into 32-bit words.
- Each word is written into the instruction memory at a word-aligned byte address, matching the fetch path's address[31:2] indexing.
- Holds the CPU in reset until the program image is fully written, then releases it.

---
 rtl/imem_loader.sv | 134 +++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module   : imem_loader
// Purpose  : Streams a program image into instruction memory and holds the
//            CPU in reset until the whole image has been written.
//            Stream: 2-byte big-endian word count N, then N big-endian words.
// Ports    : CLK, rst        - clock, synchronous active-high reset
//            in_valid/in_data/in_ready - byte stream handshake
//            imem_we/imem_addr/imem_wdata - instruction memory write port
//            cpu_rst         - CPU reset, high until the image is complete
//            done, error     - sticky status flags (cleared only by rst)
//            words_loaded    - words written since the last reset
// Revision : 1.0 - initial release
// ============================================================================
module imem_loader #(
  parameter int DEPTH = 128,
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             in_ready,
  output logic             imem_we,
  output logic [31:0]      imem_addr,
  output logic [31:0]      imem_wdata,
  output logic             cpu_rst,
  output logic             done,
  output logic             error,
  output logic [CNT_W-1:0] words_loaded
);

  // One spare bit so that an index equal to DEPTH is representable.
  localparam int WIDX_W = $clog2(DEPTH) + 1;

  typedef enum logic [2:0] {
    S_HDR_HI = 3'd0,
    S_HDR_LO = 3'd1,
    S_DATA   = 3'd2,
    S_FINISH = 3'd3,
    S_DONE   = 3'd4,
    S_ERR    = 3'd5
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [7:0]         r_cnt_hi;
  logic [CNT_W-1:0]   r_count;
  logic [1:0]         r_byte_idx;
  logic [23:0]        r_asm;       // first three bytes of the word in flight
  logic [WIDX_W-1:0]  r_word_idx;

  logic               w_accept;
  logic [15:0]        w_hdr_cnt;
  logic               w_last_word;

  assign w_accept    = in_valid && in_ready;
  assign w_hdr_cnt   = {r_cnt_hi, in_data};
  assign w_last_word = ((CNT_W'(r_word_idx) + CNT_W'(1)) == r_count);

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    case (r_state)
      S_HDR_HI: begin
        in_ready = 1'b1;
        if (w_accept) w_state_nxt = S_HDR_LO;
      end
      S_HDR_LO: begin
        in_ready = 1'b1;
        if (w_accept) begin
          if (w_hdr_cnt == 16'd0)             w_state_nxt = S_DONE;
          else if (w_hdr_cnt > 16'(DEPTH))    w_state_nxt = S_ERR;
          else                                w_state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        in_ready = 1'b1;
        if (w_accept && (r_byte_idx == 2'd3) && w_last_word)
          w_state_nxt = S_FINISH;
      end
      S_FINISH: w_state_nxt = S_DONE;
      S_DONE:   w_state_nxt = S_DONE;
      S_ERR:    w_state_nxt = S_ERR;
      default:  w_state_nxt = S_HDR_HI;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      r_state      <= S_HDR_HI;
      r_cnt_hi     <= 8'd0;
      r_count      <= '0;
      r_byte_idx   <= 2'd0;
      r_asm        <= 24'd0;
      r_word_idx   <= '0;
      imem_we      <= 1'b0;
      imem_addr    <= 32'd0;
      imem_wdata   <= 32'd0;
      cpu_rst      <= 1'b1;
      done         <= 1'b0;
      error        <= 1'b0;
      words_loaded <= '0;
    end else begin
      r_state <= w_state_nxt;
      imem_we <= 1'b0;

      if (w_accept && (r_state == S_HDR_HI)) r_cnt_hi <= in_data;
      if (w_accept && (r_state == S_HDR_LO)) r_count  <= CNT_W'(w_hdr_cnt);

      if (w_accept && (r_state == S_DATA)) begin
        if (r_byte_idx == 2'd3) begin
          imem_we      <= 1'b1;
          imem_wdata   <= {r_asm, in_data};
          imem_addr    <= 32'({r_word_idx, 2'b00});
          words_loaded <= words_loaded + CNT_W'(1);
          r_word_idx   <= r_word_idx + WIDX_W'(1);
          r_byte_idx   <= 2'd0;
        end else begin
          r_asm      <= {r_asm[15:0], in_data};
          r_byte_idx <= r_byte_idx + 2'd1;
        end
      end

      // Status follows the registered state, so the CPU leaves reset one
      // edge after FINISH, strictly after the final write has landed.
      cpu_rst <= (r_state != S_DONE);
      if (r_state == S_DONE) done  <= 1'b1;
      if (r_state == S_ERR)  error <= 1'b1;
    end
  end

endmodule
`default_nettype wire
